// File: rtl/priority_decoder_pkg.sv
// Purpose : shared types and constants for the priority_decoder block.
// Contents: FSM state type (IDLE, HOLD), counter width, number of decoded
//           lines, and a one-hot helper used by the decode path.
package priority_decoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int CNT_W     = 8;
  localparam int NUM_LINES = 4;

  // Turns a 2-bit line index into its one-hot line vector.
  function automatic logic [NUM_LINES-1:0] onehot(input logic [1:0] code);
    logic [NUM_LINES-1:0] v;
    v       = '0;
    v[code] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/hit_counter.sv
// Purpose : one saturating hit counter; clear has priority over increment.
// Ports   : clk, rst_n (async active-low), inc_i (count one hit),
//           clr_i (synchronous zero), cnt_o (current count, CNT_W bits).
module hit_counter
  import priority_decoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/priority_decoder.sv
// Purpose : decodes a 2-bit code into a one-hot line held for HOLD_CYCLES
//           cycles; optional per-line saturating hit counters.
// Ports   : clk, rst_n (async active-low); ENC/VLD code input with
//           in_ready acceptance; D_OUT one-hot line, out_active; cnt_clr and
//           hit_cnt (four 8-bit lanes, line n at [8n+7:8n]).
// Config  : define PRIORITY_DECODER_CNT_EN to build the hit counters; without
//           it hit_cnt is tied to zero and cnt_clr is ignored.
module priority_decoder
  import priority_decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 4  // legal range 1..255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  ENC,
  input  logic        VLD,
  output logic        in_ready,
  output logic [3:0]  D_OUT,
  output logic        out_active,
  input  logic        cnt_clr,
  output logic [31:0] hit_cnt
);

  // Hold counter is loaded with HOLD_CYCLES-1 so that the HOLD state spans
  // exactly HOLD_CYCLES cycles, including the cycle the counter reads zero.
  localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

  state_t                state_q, state_d;
  logic [7:0]            hold_q,  hold_d;
  logic [NUM_LINES-1:0]  dout_q,  dout_d;
  logic                  accept;

  assign in_ready = (state_q == IDLE);
  assign accept   = VLD && in_ready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (VLD) begin
          state_d = HOLD;
          dout_d  = onehot(ENC);
          hold_d  = HOLD_INIT;
        end
      end
      HOLD: begin
        // Codes presented during HOLD are not captured; the sender keeps
        // VLD up and is accepted on the next IDLE cycle instead.
        if (hold_q != 8'd0) begin
          hold_d = hold_q - 8'd1;
        end else begin
          state_d = IDLE;
          dout_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        dout_d  = '0;
        hold_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hold_q  <= 8'd0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      dout_q  <= dout_d;
    end
  end

  assign D_OUT      = dout_q;
  assign out_active = |dout_q;

`ifdef PRIORITY_DECODER_CNT_EN
  for (genvar n = 0; n < NUM_LINES; n++) begin : g_hit
    logic [CNT_W-1:0] lane_cnt;

    hit_counter u_hit_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (accept && (ENC == 2'(n))),
      .clr_i (cnt_clr),
      .cnt_o (lane_cnt)
    );

    assign hit_cnt[CNT_W*n +: CNT_W] = lane_cnt;
  end
`else
  logic unused_cnt_clr;
  logic unused_accept;
  assign unused_cnt_clr = cnt_clr;
  assign unused_accept  = accept;
  assign hit_cnt        = '0;
`endif

endmodule

// File: tb/tb_priority_decoder.sv
// Purpose : directed self-checking bench for priority_decoder; one instance
//           with the default hold length and one with HOLD_CYCLES=1.
// Ports   : none (top-level bench). Counter expectations follow
//           PRIORITY_DECODER_CNT_EN; the decode traces must match either way.
module tb_priority_decoder;

`ifdef PRIORITY_DECODER_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;

  logic [1:0]  enc;
  logic        vld;
  logic        in_ready;
  logic [3:0]  d_out;
  logic        out_active;
  logic        cnt_clr;
  logic [31:0] hit_cnt;

  logic [1:0]  enc1;
  logic        vld1;
  logic        in_ready1;
  logic [3:0]  d_out1;
  logic        out_active1;
  logic        cnt_clr1;
  logic [31:0] hit_cnt1;

  int errors;
  int checks;

  priority_decoder #(.HOLD_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ENC        (enc),
    .VLD        (vld),
    .in_ready   (in_ready),
    .D_OUT      (d_out),
    .out_active (out_active),
    .cnt_clr    (cnt_clr),
    .hit_cnt    (hit_cnt)
  );

  priority_decoder #(.HOLD_CYCLES(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ENC        (enc1),
    .VLD        (vld1),
    .in_ready   (in_ready1),
    .D_OUT      (d_out1),
    .out_active (out_active1),
    .cnt_clr    (cnt_clr1),
    .hit_cnt    (hit_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] lanes(input logic [7:0] l3, input logic [7:0] l2,
                                        input logic [7:0] l1, input logic [7:0] l0);
    return CNT_EN ? {l3, l2, l1, l0} : 32'd0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enc = 2'd0; vld = 1'b0; cnt_clr = 1'b0;
    enc1 = 2'd0; vld1 = 1'b0; cnt_clr1 = 1'b0;
    #3;
    checks++;
    if (in_ready !== 1'b1 || d_out !== 4'b0000 || out_active !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: in_ready=%b d_out=%b out_active=%b, need 1 0000 0",
               in_ready, d_out, out_active);
    end
    checks++;
    if (hit_cnt !== 32'd0 || hit_cnt1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_cnt: hit_cnt=%h hit_cnt1=%h, need 0", hit_cnt, hit_cnt1);
    end
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Single code, ENC=2: line high for cycles 1..4, released at cycle 5.
  task automatic test_single();
    int bad;
    bad = 0;
    enc = 2'd2; vld = 1'b1;
    step();
    vld = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (d_out !== 4'b0100 || out_active !== 1'b1 || in_ready !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL single_hold: %0d bad cycles of 4, last d_out=%b, need 0100", bad, d_out);
    end
    checks++;
    if (d_out !== 4'b0000 || out_active !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_release: d_out=%b act=%b rdy=%b, need 0000 0 1",
               d_out, out_active, in_ready);
    end
  endtask

  // VLD held with ENC=3: line high on 4 of every 5 cycles.
  task automatic test_back_to_back();
    int bad;
    logic [3:0] exp_d;
    bad = 0;
    enc = 2'd3; vld = 1'b1;
    step();
    for (int t = 1; t <= 15; t++) begin
      exp_d = ((t % 5) != 0) ? 4'b1000 : 4'b0000;
      if (d_out !== exp_d || in_ready !== (exp_d == 4'b0000)) bad++;
      if (t == 15) vld = 1'b0;
      else step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL back_to_back: %0d bad cycles of 15, need 1000 on t%%5!=0", bad);
    end
    step();
    checks++;
    if (d_out !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_stop: d_out=%b, need 0000", d_out);
    end
  endtask

  // A VLD pulse that lands inside HOLD must neither alter nor queue.
  task automatic test_ignore_in_hold();
    int bad;
    bad = 0;
    enc = 2'd0; vld = 1'b1;
    step();
    vld = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      if (t == 2) begin enc = 2'd1; vld = 1'b1; end
      if (t == 3) vld = 1'b0;
      if (t <= 4 && d_out !== 4'b0001) bad++;
      if (t >= 5 && d_out !== 4'b0000) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ignore_in_hold: %0d bad cycles of 7, last d_out=%b", bad, d_out);
    end
    checks++;
    if (hit_cnt !== lanes(8'd3, 8'd1, 8'd0, 8'd1)) begin
      errors++;
      $display("FAIL hits_after_ignore: hit_cnt=%h, need %h",
               hit_cnt, lanes(8'd3, 8'd1, 8'd0, 8'd1));
    end
  endtask

  // HOLD_CYCLES=1, ENC=0 held: alternating one-cycle pulses.
  task automatic test_hold1();
    int bad;
    logic [3:0] exp_d;
    bad = 0;
    enc1 = 2'd0; vld1 = 1'b1;
    step();
    for (int t = 1; t <= 6; t++) begin
      exp_d = (t % 2 == 1) ? 4'b0001 : 4'b0000;
      if (d_out1 !== exp_d || out_active1 !== (exp_d != 4'b0000)) bad++;
      if (t == 6) vld1 = 1'b0;
      else step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold1_pattern: %0d bad cycles of 6, last d_out1=%b", bad, d_out1);
    end
    step();
    checks++;
    if (d_out1 !== 4'b0000 || in_ready1 !== 1'b1) begin
      errors++;
      $display("FAIL hold1_idle: d_out1=%b rdy=%b, need 0000 1", d_out1, in_ready1);
    end
  endtask

  // Reset in cycle 2 of a hold acts without an edge; accept right after release.
  task automatic test_reset_mid_hold();
    enc = 2'd1; vld = 1'b1;
    step();
    vld = 1'b0;
    step();
    checks++;
    if (d_out !== 4'b0010) begin
      errors++;
      $display("FAIL pre_reset_hold: d_out=%b, need 0010", d_out);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (d_out !== 4'b0000 || out_active !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: d_out=%b act=%b rdy=%b, need 0000 0 1",
               d_out, out_active, in_ready);
    end
    checks++;
    if (hit_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset_clears_cnt: hit_cnt=%h, need 0", hit_cnt);
    end
    #1;
    rst_n = 1'b1;
    enc = 2'd2; vld = 1'b1;
    step();
    vld = 1'b0;
    checks++;
    if (d_out !== 4'b0100 || out_active !== 1'b1) begin
      errors++;
      $display("FAIL first_after_reset: d_out=%b act=%b, need 0100 1", d_out, out_active);
    end
    for (int k = 0; k < 4; k++) step();
    checks++;
    if (d_out !== 4'b0000 || hit_cnt !== lanes(8'd0, 8'd1, 8'd0, 8'd0)) begin
      errors++;
      $display("FAIL after_reset_hold: d_out=%b hit_cnt=%h, need 0000 %h",
               d_out, hit_cnt, lanes(8'd0, 8'd1, 8'd0, 8'd0));
    end
  endtask

  // 300 acceptances of ENC=1 on the HOLD_CYCLES=1 instance, then clear.
  task automatic test_counter_sat();
    int bad;
    logic [3:0] exp_d;
    bad = 0;
    enc1 = 2'd1; vld1 = 1'b1;
    step();
    for (int t = 1; t <= 600; t++) begin
      exp_d = (t % 2 == 1) ? 4'b0010 : 4'b0000;
      if (d_out1 !== exp_d) bad++;
      if (t == 507) begin
        checks++;
        if (hit_cnt1 !== lanes(8'd0, 8'd0, 8'd254, 8'd0)) begin
          errors++;
          $display("FAIL cnt_254: hit_cnt1=%h, need %h",
                   hit_cnt1, lanes(8'd0, 8'd0, 8'd254, 8'd0));
        end
      end
      if (t == 509) begin
        checks++;
        if (hit_cnt1 !== lanes(8'd0, 8'd0, 8'd255, 8'd0)) begin
          errors++;
          $display("FAIL cnt_255: hit_cnt1=%h, need %h",
                   hit_cnt1, lanes(8'd0, 8'd0, 8'd255, 8'd0));
        end
      end
      if (t == 599) begin
        checks++;
        if (hit_cnt1 !== lanes(8'd0, 8'd0, 8'd255, 8'd0)) begin
          errors++;
          $display("FAIL cnt_saturated: hit_cnt1=%h, need %h",
                   hit_cnt1, lanes(8'd0, 8'd0, 8'd255, 8'd0));
        end
      end
      if (t == 600) cnt_clr1 = 1'b1;
      else step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sat_trace: %0d bad cycles of 600", bad);
    end
    // Clear coincides with the acceptance on this edge.
    step();
    cnt_clr1 = 1'b0;
    vld1 = 1'b0;
    checks++;
    if (hit_cnt1 !== 32'd0 || d_out1 !== 4'b0010) begin
      errors++;
      $display("FAIL clear_wins: hit_cnt1=%h d_out1=%b, need 0 0010", hit_cnt1, d_out1);
    end
    step();
    enc1 = 2'd3; vld1 = 1'b1;
    step();
    vld1 = 1'b0;
    checks++;
    if (hit_cnt1 !== lanes(8'd1, 8'd0, 8'd0, 8'd0) || d_out1 !== 4'b1000) begin
      errors++;
      $display("FAIL count_after_clear: hit_cnt1=%h d_out1=%b, need %h 1000",
               hit_cnt1, d_out1, lanes(8'd1, 8'd0, 8'd0, 8'd0));
    end
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_in_hold();
    test_hold1();
    test_reset_mid_hold();
    test_counter_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
